// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq
//   Sequential BCD-to-binary converter. A packed DIGITS-digit BCD word is
//   accepted on a start/ready handshake. It is then folded most-significant
//   digit first, one digit per clock, as acc = acc*10 + digit. The multiply
//   by ten is done with shifts and an add only. Any nibble above 9 sets Err
//   and forces Bin to zero.
//
// Handshake: a conversion is accepted on any rising edge where Start=1 and
//   Ready=1. Ready is high exactly while the FSM is in IDLE, and BCD is
//   sampled only on that accepting edge. Done is a one-cycle pulse that marks
//   the cycle in which Bin/Err first hold the new result. That cycle is
//   itself an IDLE cycle, so Start may be accepted in it.
//
// Ports:
//   CLK        rising-edge clock
//   RST        synchronous active-high reset, priority over Start
//   Start      conversion request, sampled only while Ready=1
//   BCD        packed operand, most-significant digit in the top nibble
//   Ready      high in IDLE
//   Done       one-cycle result strobe
//   Bin        binary result, held until the next Done or reset
//   Err        non-decimal nibble seen in the accepted operand, held with Bin
//   state_dbg  current FSM state (0 = IDLE, 1 = CONV)
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start,
  input  logic [4*DIGITS-1:0]   BCD,
  output logic                  Ready,
  output logic                  Done,
  output logic [BIN_W-1:0]      Bin,
  output logic                  Err,
  output logic                  state_dbg
);

  // Four spare accumulator bits absorb the growth caused by invalid digits.
  // Those results are forced to zero anyway, so the extra bits only keep the
  // arithmetic well defined.
  localparam int ACC_W = BIN_W + 4;
  localparam int CNT_W = $clog2(DIGITS + 1);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_CONV = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIGITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic                 state;
  logic [4*DIGITS-1:0]  shift_reg;
  logic [ACC_W-1:0]     acc;
  logic [CNT_W-1:0]     cnt;
  logic                 err_acc;

  logic [3:0]           digit;
  logic [ACC_W-1:0]     acc_next;
  logic                 err_next;
  logic                 last_digit;

  always_comb begin
    digit      = shift_reg[4*DIGITS-1 -: 4];
    // acc*10 = acc*8 + acc*2
    acc_next   = (acc << 3) + (acc << 1) + {{(ACC_W-4){1'b0}}, digit};
    // The error check of the final digit is folded in before the result is
    // committed.
    err_next   = err_acc | (digit > 4'd9);
    last_digit = (cnt == CNT_ONE);
    Ready      = (state == S_IDLE);
    state_dbg  = state;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      acc       <= '0;
      cnt       <= '0;
      err_acc   <= 1'b0;
      Done      <= 1'b0;
      Bin       <= '0;
      Err       <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            shift_reg <= BCD;
            acc       <= '0;
            cnt       <= CNT_LOAD;
            err_acc   <= 1'b0;
            state     <= S_CONV;
          end
        end
        S_CONV: begin
          acc       <= acc_next;
          shift_reg <= shift_reg << 4;
          err_acc   <= err_next;
          cnt       <= cnt - CNT_ONE;
          if (last_digit) begin
            Bin   <= err_next ? '0 : acc_next[BIN_W-1:0];
            Err   <= err_next;
            Done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq
//   Bench for bcd_to_bin_seq with DIGITS=4 and BIN_W=14. It applies the
//   directed cases first and then randomized operands. Every accepted
//   operand is converted by a positional-weight model (sum of digit*10^i)
//   and queued. Each Done pops the queue and compares Bin, Err and the
//   accept-to-Done edge count.
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int W      = BIN_W + 1;   // {err, bin}

  // ---------------- clock / reset ----------------
  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic                Start = 1'b0;
  logic [4*DIGITS-1:0] BCD = '0;
  logic                Ready;
  logic                Done;
  logic [BIN_W-1:0]    Bin;
  logic                Err;
  logic                state_dbg;

  always #5 CLK = ~CLK;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Start     (Start),
    .BCD       (BCD),
    .Ready     (Ready),
    .Done      (Done),
    .Bin       (Bin),
    .Err       (Err),
    .state_dbg (state_dbg)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input logic [4*DIGITS-1:0] v);
    int sum   = 0;
    int scale = 1;
    bit bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      int n;
      n = int'(v[4*d +: 4]);
      if (n > 9) bad_digit = 1'b1;
      sum   += n * scale;
      scale *= 10;
    end
    if (bad_digit) return {1'b1, {BIN_W{1'b0}}};
    return {1'b0, BIN_W'(sum)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  int           cyc = 0;
  logic         mon_en = 1'b0;
  logic         rst_last = 1'b1;
  logic [BIN_W-1:0] prev_bin = '0;

  // Acceptance is observed at the edge itself. Inputs change only on
  // negedges, so the values seen here are the ones the design samples.
  always @(posedge CLK) begin
    cyc      <= cyc + 1;
    rst_last <= RST;
    if (RST) begin
      exp_q.delete();
      cyc_q.delete();
    end else if (Start && Ready) begin
      exp_q.push_back(model(BCD));
      cyc_q.push_back(cyc);
    end
  end

  always @(negedge CLK) begin
    if (mon_en) begin
      if (Done) begin
        check("done_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          logic [W-1:0] e;
          int           c;
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          check("bin", 32'(Bin), 32'(e[BIN_W-1:0]));
          check("err", 32'(Err), 32'(e[BIN_W]));
          check("latency", 32'(cyc - c), 32'(DIGITS + 1));
          check("ready_in_done", 32'(Ready), 32'd1);
        end
      end else if (!rst_last && Bin !== prev_bin) begin
        check("bin_hold", 32'(Bin), 32'(prev_bin));
      end
    end
    prev_bin <= Bin;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    while (Ready !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (Ready !== 1'b1) check("ready_timeout", 32'(Ready), 32'd1);
  endtask

  // Presents one operand with a single-cycle Start, aligned to a negedge.
  task automatic convert(input logic [4*DIGITS-1:0] v);
    @(negedge CLK);
    wait_ready();
    BCD   = v;
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge CLK);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge CLK);
  endtask

  task automatic wait_done();
    int n = 0;
    while (Done !== 1'b1 && n < 30) begin
      @(negedge CLK);
      n++;
    end
    check("done_seen", 32'(Done), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4*DIGITS-1:0] v;
    int                  t0;
    int                  t1;

    repeat (3) @(negedge CLK);
    check("rst_ready", 32'(Ready), 32'd1);
    check("rst_done",  32'(Done),  32'd0);
    check("rst_bin",   32'(Bin),   32'd0);
    check("rst_err",   32'(Err),   32'd0);
    RST    = 1'b0;
    mon_en = 1'b1;

    // 1234 with explicit Ready-low window and Done timing
    @(negedge CLK);
    BCD   = 16'h1234;
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    check("t1_ready_low", 32'(Ready), 32'd0);
    for (int i = 0; i < DIGITS - 1; i++) begin
      @(negedge CLK);
      check("t1_ready_low", 32'(Ready), 32'd0);
    end
    @(negedge CLK);
    check("t1_done", 32'(Done),  32'd1);
    check("t1_bin",  32'(Bin),   32'd1234);
    check("t1_err",  32'(Err),   32'd0);
    check("t1_ready", 32'(Ready), 32'd1);
    drain();

    // maximum value, then zero
    convert(16'h9999);
    drain();
    check("max_bin", 32'(Bin), 32'd9999);
    convert(16'h0000);
    wait_done();
    check("zero_bin", 32'(Bin), 32'd0);
    check("zero_err", 32'(Err), 32'd0);
    drain();

    // invalid nibbles in middle, top and bottom positions
    convert(16'h12A4);
    drain();
    check("mid_err", 32'(Err), 32'd1);
    check("mid_bin", 32'(Bin), 32'd0);
    convert(16'h0042);
    drain();
    check("after_err_bin", 32'(Bin), 32'd42);
    check("after_err_err", 32'(Err), 32'd0);
    convert(16'hF000);
    drain();
    check("top_err", 32'(Err), 32'd1);
    convert(16'h000B);
    drain();
    check("last_err", 32'(Err), 32'd1);
    check("last_bin", 32'(Bin), 32'd0);

    // Start held high; BCD changed right after the first accept
    @(negedge CLK);
    BCD   = 16'h0505;
    Start = 1'b1;
    @(negedge CLK);
    BCD = 16'h9999;
    wait_done();
    t0 = cyc;
    check("held_first", 32'(Bin), 32'd505);
    @(negedge CLK);
    wait_done();
    t1 = cyc;
    Start = 1'b0;
    check("held_second", 32'(Bin), 32'd9999);
    check("held_period", 32'(t1 - t0), 32'(DIGITS + 1));
    drain();

    // reset two edges into a conversion aborts it
    @(negedge CLK);
    BCD   = 16'h4321;
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("abort_ready", 32'(Ready), 32'd1);
    check("abort_bin",   32'(Bin),   32'd0);
    check("abort_err",   32'(Err),   32'd0);
    check("abort_done",  32'(Done),  32'd0);
    repeat (DIGITS + 2) begin
      @(negedge CLK);
      check("abort_no_done", 32'(Done), 32'd0);
    end
    convert(16'h4321);
    drain();
    check("post_abort_bin", 32'(Bin), 32'd4321);

    // Start raised exactly in the Done cycle
    convert(16'h0777);
    wait_done();
    check("done_cycle_ready", 32'(Ready), 32'd1);
    BCD   = 16'h8016;
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    check("done_cycle_accept", 32'(Ready), 32'd0);
    drain();
    check("done_cycle_bin", 32'(Bin), 32'd8016);

    // randomized operands, some with a non-decimal nibble
    for (int k = 0; k < 40; k++) begin
      for (int d = 0; d < DIGITS; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 4) == 0) v[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      convert(v);
      repeat ($urandom_range(0, 6)) @(negedge CLK);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_seq.md
# bcd_to_bin_seq

Sequential BCD-to-binary converter: it takes a packed multi-digit BCD word, as produced by the team's BCD digit-adder chain, and returns its binary value. Digits are processed most-significant first, one per clock, using acc = acc*10 + digit, with shift-and-add only (no multiplier). The block is the decode path that lets BCD arithmetic results feed binary datapaths and comparators. It uses a start/ready/done handshake and flags any non-decimal nibble.

## Interface
Parameters:
- DIGITS, default 4: number of BCD digits per conversion.
- BIN_W, default 14: result width. Must be ≥ ceil(log2(10^DIGITS)); 14 for 4 digits.

Ports:
- CLK, input, 1: single clock; all state changes on the rising edge.
- RST, input, 1: synchronous, active-high reset.
- Start, input, 1: request a conversion. Sampled only when Ready=1.
- BCD, input, 4*DIGITS: packed BCD operand; nibble [4*DIGITS-1 -: 4] is the most-significant digit. Sampled only on the accepting edge.
- Ready, output, 1: high in IDLE; a conversion may be accepted.
- Done, output, 1: one-cycle pulse when Bin and Err are updated.
- Bin, output, BIN_W: binary result. Held stable until the next Done.
- Err, output, 1: high if any nibble of the accepted operand was >9. Held with Bin.

## Operation
- States: IDLE, CONV.
- **IDLE**
  - Ready=1.
  - When Start=1 at an edge: latch BCD into the digit shift register, clear acc, load the digit counter with DIGITS, clear the error accumulator, go to CONV.
- **CONV**
  - Ready=0.
  - Each edge: d = top nibble of the shift register; acc ← (acc<<3)+(acc<<1)+d; shift register ← shift register<<4; err_acc ← err_acc | (d>9); counter decrements.
  - Start, and any change on BCD, are ignored during CONV.
- **Completion** (edge processing the last digit):
  - Bin ← final acc, or 0 if the error flag is set, including the final digit's check.
  - Err ← error flag.
  - Done=1 for the following cycle; state returns to IDLE.
- Arithmetic:
  - acc is BIN_W+4 bits internally so invalid digits cannot corrupt the datapath before forcing.
  - Bin is exact for all valid operands (max 10^DIGITS−1).
- Back-to-back: the cycle with Done=1 is an IDLE cycle with Ready=1. Start=1 in that cycle is accepted.
- Start held continuously high gives one conversion every DIGITS+1 cycles.
- **Reset**
  - RST=1 at an edge forces IDLE, Ready=1, Done=0, Bin=0, Err=0, and clears acc, counter and shift register.
  - RST has priority over Start.
  - Reset during CONV aborts the conversion: no Done, and Bin/Err go to 0.

## Timing
- Reset values: Ready=1, Done=0, Bin=0, Err=0.
- Start accepted at edge k:
  - Ready=0 from k.
  - Digits processed at edges k+1 … k+DIGITS.
  - Done=1, with Bin/Err valid, during the cycle after edge k+DIGITS.
  - Ready=1 in that same cycle.
- Latency is DIGITS+1 edges from accept to Done (5 for the default).
- All outputs are registered; there is no combinational path from Start or BCD to any output.
- Bin/Err change only at the edge that raises Done, or at reset.

## Test plan
- Reset, then BCD=16'h1234 with a one-cycle Start: Done exactly 5 edges after the accept edge, Bin=1234 (14'h04D2), Err=0, Ready low for 4 cycles.
- BCD=16'h9999: Bin=9999 (14'h270F), Err=0. Then BCD=16'h0000: Bin=0, Err=0, and Done still pulses.
- BCD=16'h12A4: Err=1, Bin=0. Then BCD=16'h0042: Err=0, Bin=42. Repeat with an invalid top nibble 16'hF000 and an invalid last nibble 16'h000B: both give Err=1.
- Start held high with BCD=16'h0505, with BCD changed to 16'h9999 one cycle after accept:
  - First Done gives Bin=505.
  - Done repeats every 5 cycles.
  - The second result is 9999, proving BCD is sampled only on accepting edges.
- RST asserted for one cycle, 2 edges into a conversion of 16'h4321:
  - Next cycle: Ready=1, Bin=0, Err=0, and no Done pulse.
  - A fresh conversion afterwards returns 4321.
- Start asserted exactly in the Done cycle: accepted, and the next Done follows 5 edges later with the correct value.
